// File: rtl/shifter_operand.sv
// Operand-2 generator for the ARM data-processing datapath: decodes the
// 12-bit shifter_operand field into the ALU inputB value and shifter carry-out.
//
// state | meaning
// EMPTY | no result held; ready for a new instruction
// BUSY  | register-specified shift in progress from latched operands
// FULL  | operand/shift_carry valid, waiting for the ALU to consume
module shifter_operand (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        i_bit,
    input  logic [11:0] instr,
    input  logic [31:0] rm_val,
    input  logic [31:0] rs_val,
    input  logic        c_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] operand,
    output logic        shift_carry
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;

    state_t      state;
    state_t      state_next;

    logic        lat_i_bit;
    logic [11:0] lat_instr;
    logic [31:0] lat_rm;
    logic [7:0]  lat_rs;
    logic        lat_c;

    logic        src_i_bit;
    logic [11:0] src_instr;
    logic [31:0] src_rm;
    logic [7:0]  src_rs;
    logic        src_c;

    logic [32:0] result;
    logic        load_result;
    logic        latch_operands;
    logic        in_is_rsh;
    logic        unused_rs_hi;

    assign unused_rs_hi = ^rs_val[31:8];

    // Rotate right by a; carry-out is the new bit 31. Returns {carry, value}.
    function automatic logic [32:0] rotate_right(input logic [31:0] v, input logic [4:0] a);
        logic [63:0] t;
        t = {v, v} >> a;
        return {t[31], t[31:0]};
    endfunction

    // Shift by a nonzero amount in 1..31, shared by the ISH and RSH forms.
    function automatic logic [32:0] shift_core(input logic [1:0]  sh_type,
                                               input logic [31:0] rm,
                                               input logic [4:0]  a);
        logic [32:0] r;
        case (sh_type)
            SH_LSL:  r = {rm[5'd0 - a], rm << a};
            SH_LSR:  r = {rm[a - 5'd1], rm >> a};
            SH_ASR:  r = {rm[a - 5'd1], 32'($signed(rm) >>> a)};
            default: r = rotate_right(rm, a);
        endcase
        return r;
    endfunction

    function automatic logic [32:0] imm_form(input logic [11:0] ins, input logic c);
        logic [4:0]  rot;
        logic [32:0] r;
        rot = {ins[11:8], 1'b0};
        r   = rotate_right({24'b0, ins[7:0]}, rot);
        if (rot == 5'd0) begin
            r[32] = c;
        end
        return r;
    endfunction

    // Amount 0 in the immediate-shift encoding stands for LSR/ASR #32 and RRX.
    function automatic logic [32:0] ish_form(input logic [11:0] ins,
                                             input logic [31:0] rm,
                                             input logic        c);
        logic [4:0]  n;
        logic [32:0] r;
        n = ins[11:7];
        if (n != 5'd0) begin
            r = shift_core(ins[6:5], rm, n);
        end else begin
            case (ins[6:5])
                SH_LSL:  r = {c, rm};
                SH_LSR:  r = {rm[31], 32'd0};
                SH_ASR:  r = {rm[31], {32{rm[31]}}};
                default: r = {rm[0], c, rm[31:1]};
            endcase
        end
        return r;
    endfunction

    function automatic logic [32:0] rsh_form(input logic [11:0] ins,
                                             input logic [31:0] rm,
                                             input logic [7:0]  s,
                                             input logic        c);
        logic [32:0] r;
        if (s == 8'd0) begin
            r = {c, rm};
        end else if (s < 8'd32) begin
            r = shift_core(ins[6:5], rm, s[4:0]);
        end else begin
            case (ins[6:5])
                SH_LSL:  r = (s == 8'd32) ? {rm[0], 32'd0} : 33'd0;
                SH_LSR:  r = (s == 8'd32) ? {rm[31], 32'd0} : 33'd0;
                SH_ASR:  r = {rm[31], {32{rm[31]}}};
                default: r = (s[4:0] == 5'd0) ? {rm[31], rm}
                                              : shift_core(ins[6:5], rm, s[4:0]);
            endcase
        end
        return r;
    endfunction

    assign in_is_rsh = !i_bit && instr[4];
    assign out_valid = (state == FULL);

    always_comb begin
        src_i_bit = i_bit;
        src_instr = instr;
        src_rm    = rm_val;
        src_rs    = rs_val[7:0];
        src_c     = c_in;
        if (state == BUSY) begin
            src_i_bit = lat_i_bit;
            src_instr = lat_instr;
            src_rm    = lat_rm;
            src_rs    = lat_rs;
            src_c     = lat_c;
        end
    end

    always_comb begin
        result = 33'd0;
        if (src_i_bit) begin
            result = imm_form(src_instr, src_c);
        end else if (!src_instr[4]) begin
            result = ish_form(src_instr, src_rm, src_c);
        end else begin
            result = rsh_form(src_instr, src_rm, src_rs, src_c);
        end
    end

    always_comb begin
        state_next     = state;
        in_ready       = 1'b0;
        load_result    = 1'b0;
        latch_operands = 1'b0;
        case (state)
            EMPTY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_is_rsh) begin
                        state_next     = BUSY;
                        latch_operands = 1'b1;
                    end else begin
                        state_next  = FULL;
                        load_result = 1'b1;
                    end
                end
            end
            BUSY: begin
                state_next  = FULL;
                load_result = 1'b1;
            end
            FULL: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        if (in_is_rsh) begin
                            state_next     = BUSY;
                            latch_operands = 1'b1;
                        end else begin
                            load_result = 1'b1;
                        end
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            operand     <= 32'd0;
            shift_carry <= 1'b0;
            lat_i_bit   <= 1'b0;
            lat_instr   <= 12'd0;
            lat_rm      <= 32'd0;
            lat_rs      <= 8'd0;
            lat_c       <= 1'b0;
        end else begin
            state <= state_next;
            if (load_result) begin
                shift_carry <= result[32];
                operand     <= result[31:0];
            end
            if (latch_operands) begin
                lat_i_bit <= i_bit;
                lat_instr <= instr;
                lat_rm    <= rm_val;
                lat_rs    <= rs_val[7:0];
                lat_c     <= c_in;
            end
        end
    end

endmodule

// File: doc/shifter_operand.md
# shifter_operand

Operand-2 generator for the ARM data-processing datapath, placed directly upstream of the ALU. It decodes the 12-bit shifter_operand field plus the I bit. It produces the 32-bit value driven onto the ALU `inputB`, and the shifter carry-out used for the C flag of logical ops. The block is a one-entry registered stage with valid/ready handshakes on both sides. Register-specified shifts take one extra cycle, matching the extra Rs-read cycle of the core.

## Interface
- Parameters: none; the datapath is fixed at 32 bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream offers an instruction.
- in_ready  out  1  block accepts the offer this cycle.
- i_bit  in  1  instruction bit 25; 1 selects the rotated-immediate form.
- instr  in  12  instruction bits [11:0].
- rm_val  in  32  Rm register value.
- rs_val  in  32  Rs register value; only bits [7:0] are used.
- c_in  in  1  current CPSR C flag.
- out_valid  out  1  operand and shift_carry are valid.
- out_ready  in  1  ALU stage consumes the result.
- operand  out  32  shifter result, drives ALU `inputB`.
- shift_carry  out  1  shifter carry-out.

## Operation
- Handshake: a transfer occurs on clk when valid && ready. All inputs are sampled only on an accepted cycle.
- Form selection:
  - IMM: i_bit=1.
  - ISH (immediate shift): i_bit=0, instr[4]=0.
  - RSH (register shift): i_bit=0, instr[4]=1. instr[7] is ignored.
- Shift type = instr[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- IMM form:
  - operand = {24'b0, instr[7:0]} rotated right by 2*instr[11:8].
  - carry = c_in if the rotate amount is 0, else operand[31].
- ISH form, n = instr[11:7]:
  - LSL: n=0 gives rm, c_in. Otherwise rm<<n, carry rm[32-n].
  - LSR: n=0 means 32 and gives 0, carry rm[31]. Otherwise rm>>n, carry rm[n-1].
  - ASR: n=0 means 32 and gives {32{rm[31]}}, carry rm[31]. Otherwise arithmetic shift, carry rm[n-1].
  - ROR: n=0 is RRX and gives {c_in, rm[31:1]}, carry rm[0]. Otherwise rotate, carry rm[n-1].
- RSH form, s = rs_val[7:0] (8-bit, 0..255). In every type, s=0 gives rm, c_in.
  - LSL: 1..31 gives rm<<s, carry rm[32-s]. 32 gives 0, carry rm[0]. Above 32 gives 0, carry 0.
  - LSR: 1..31 gives rm>>s, carry rm[s-1]. 32 gives 0, carry rm[31]. Above 32 gives 0, carry 0.
  - ASR: 1..31 gives an arithmetic shift, carry rm[s-1]. 32 or more gives {32{rm[31]}}, carry rm[31].
  - ROR: if s[4:0]=0 (s nonzero), gives rm, carry rm[31]. Otherwise rotate by s[4:0], carry rm[s[4:0]-1].
- State machine (EMPTY, BUSY, FULL):
  - EMPTY: in_ready=1. An accepted IMM/ISH goes to FULL with the result registered. An accepted RSH goes to BUSY with i_bit, instr, rm_val, rs_val[7:0] and c_in latched.
  - BUSY: in_ready=0. Computes from the latched operands and always goes to FULL on the next edge.
  - FULL: out_valid=1, in_ready=out_ready. On out_ready:
    - an accepted IMM/ISH stays in FULL with the new result;
    - an accepted RSH goes to BUSY, and out_valid drops;
    - with no input it goes to EMPTY.
  - FULL with out_ready=0 holds operand and shift_carry stable.
- No combinational path from in_* to operand/shift_carry. in_ready depends combinationally only on state and out_ready.

## Timing
- Reset (asynchronous, rst_n=0): state=EMPTY, out_valid=0, operand=0, shift_carry=0, all latched operands=0. in_ready=1 once in EMPTY.
- Reset mid-operation: an in-flight BUSY or FULL entry is discarded with no output.
- Latency, accept edge to out_valid: IMM/ISH 1 cycle, RSH 2 cycles.
- Throughput: IMM/ISH 1 per cycle under out_ready=1; RSH 1 per 2 cycles.
- in_valid may be asserted while rst_n is low; no transfer occurs.

## Test plan
- IMM: i_bit=1, instr=12'h4FF, c_in=0, out_ready=1. Required: out_valid exactly 1 cycle after accept, operand=32'hFF000000, shift_carry=1. Repeat with instr=12'h0FF and c_in=1: operand=32'h000000FF, shift_carry=1.
- ISH RRX/LSR#32: instr=12'h060, rm=32'h00000003, c_in=1 gives operand=32'h80000001, shift_carry=1. instr=12'h020, rm=32'h80000000 gives operand=0, shift_carry=1.
- RSH LSL boundaries: instr=12'h010, rm=32'h00000001.
  - rs=32: operand=0, carry=1.
  - rs=33: operand=0, carry=0.
  - rs=32'h00000100 (low byte 0) with c_in=1: operand=1, carry=1.
  - Each result arrives 2 cycles after accept, with in_ready=0 during BUSY.
- RSH ROR: instr=12'h070, rm=32'h80000001, rs=32 gives operand=32'h80000001, carry=1. rs=4 gives operand=32'h18000000, carry=0.
- Backpressure: hold out_ready=0 in FULL with in_valid=1. Required: in_ready=0 and operand stable for 5 cycles. Then raise out_ready with back-to-back ISH inputs: one result per cycle, none lost or duplicated, order preserved.
- Reset in BUSY: assert rst_n=0 one cycle after an RSH accept. Required: out_valid=0, operand=0, shift_carry=0 immediately, and no result after release.
